// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES carry-chained chunks, valid/ready stream.
// Define PADD_SUB_EN to add the sub port (a - b - cin); otherwise the block is add-only.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Handshake: a transfer happens on any edge where valid and ready are both high.
  // Every stage shifts together when the output slot is empty or being drained.
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

`ifdef PADD_SUB_EN
  // Subtraction is folded into operand B and carry-in before stage 0.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k + 1) * CW;
    localparam int HI = WIDTH - LO;

    logic [CW-1:0] op_a;
    logic [CW-1:0] op_b;
    logic          c_in;
    logic          v_in;
    logic [CW:0]   chunk;
    logic [LO-1:0] s_nx;
    logic [LO-1:0] s_q;
    logic          v_q;
    logic          c_q;

    if (k == 0) begin : g_src
      assign op_a = a[CW-1:0];
      assign op_b = b_eff[CW-1:0];
      assign c_in = cin_eff;
      assign v_in = in_valid;
      assign s_nx = chunk[CW-1:0];
    end else begin : g_src
      assign op_a = g_stage[k-1].g_fwd.a_q[CW-1:0];
      assign op_b = g_stage[k-1].g_fwd.b_q[CW-1:0];
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_nx = {chunk[CW-1:0], g_stage[k-1].s_q};
    end

    assign chunk = {1'b0, op_a} + {1'b0, op_b} + {{CW{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= chunk[CW];
        s_q <= s_nx;
      end
    end

    // Operand chunks not yet summed ride along with the stage (skew registers).
    if (HI > 0) begin : g_fwd
      logic [HI-1:0] a_nx;
      logic [HI-1:0] b_nx;
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;

      if (k == 0) begin : g_in
        assign a_nx = a[WIDTH-1:CW];
        assign b_nx = b_eff[WIDTH-1:CW];
      end else begin : g_in
        assign a_nx = g_stage[k-1].g_fwd.a_q[HI+CW-1:CW];
        assign b_nx = g_stage[k-1].g_fwd.b_q[HI+CW-1:CW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end
  end

  // Carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= g_stage[STAGES-1].chunk[CW-1] ^ g_stage[STAGES-1].op_a[CW-1]
             ^ g_stage[STAGES-1].op_b[CW-1] ^ g_stage[STAGES-1].chunk[CW];
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed latency/stall/reset steps plus randomized traffic vs an arithmetic model.
module tb_pipelined_adder;
  localparam int W  = 16;
  localparam int ST = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;
  logic         rand_ready = 1'b0;
  logic [W+1:0] exp_q[$];
  logic         prev_hold = 1'b0;
  logic [W+1:0] prev_out  = '0;

  pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PADD_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    longint ux, uy, sx, sy, r, sr, smax, smin;
    logic co, ov;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    if (!sb) begin
      r  = ux + uy + longint'(ci);
      sr = sx + sy + longint'(ci);
      co = (r >= (longint'(1) << W));
    end else begin
      r  = ux - uy - longint'(ci);
      sr = sx - sy - longint'(ci);
      co = (ux >= uy + longint'(ci));
    end
    ov = (sr > smax) || (sr < smin);
    return {ov, co, r[W-1:0]};
  endfunction

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {ovf, cout, s}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
        else check("result", {ovf, cout, s}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub_i));
      prev_hold = out_valid && !out_ready;
      prev_out  = {ovf, cout, s};
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    logic acc;
    int n;
    a = x; b = y; cin = ci; sub_i = sb; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 64);
    if (!acc) check("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic latency_test(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic ci, input logic sb,
                              input logic [W-1:0] es, input logic ec, input logic eo);
    a = x; b = y; cin = ci; sub_i = sb; in_valid = 1'b1;
    for (int j = 0; j <= ST; j++) begin
      @(negedge clk);
      check($sformatf("%s_valid_c%0d", tag, j), out_valid, (j == ST));
      if (j == ST) begin
        check({tag, "_s"}, s, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
      end
      step();
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Directed and randomized steps
  initial begin
    logic [W+1:0] first_exp;
    logic [W-1:0] ra, rb;
    logic         rsub;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    step();

    latency_test("t1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    latency_test("t2a", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    latency_test("t2b", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    latency_test("t2c", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain();

    // Back-to-back: 8 results on 8 consecutive cycles.
    for (int j = 0; j <= ST + 8; j++) begin
      if (j < 8) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_i = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j >= ST) check($sformatf("t3_valid_c%0d", j), out_valid, (j < ST + 8));
      step();
    end
    drain();

    // Stall with full pipe, then simultaneous pop and push.
    out_ready = 1'b0;
    first_exp = model(16'h1234, 16'h0F0F, 1'b1, 1'b0);
    send(16'h1234, 16'h0F0F, 1'b1, 1'b0);
    for (int i = 1; i < ST; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    a = 16'hA5A5; b = 16'h5A5A; cin = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("t4_in_ready_c%0d", j), in_ready, 0);
      check($sformatf("t4_out_valid_c%0d", j), out_valid, 1);
      check($sformatf("t4_s_c%0d", j), s, first_exp[W-1:0]);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_pop_push_ready", in_ready, 1);
    step();
    drain();

    // Asynchronous reset with two operations in flight.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_s", s, 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int j = 0; j < ST + 4; j++) begin
      @(negedge clk);
      check($sformatf("t5_no_stale_c%0d", j), out_valid, 0);
      step();
    end

`ifdef PADD_SUB_EN
    latency_test("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    latency_test("t6b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain();
`endif

    // Randomized traffic with bubbles and backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ra = pick_operand();
      rb = pick_operand();
`ifdef PADD_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      send(ra, rb, 1'($urandom), rsub);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
